// File: rtl/regfile_bist.sv
// regfile_bist
//   Built-in self-test initiator for the 8-entry register file. It runs two passes:
//   one with a generated pattern and one with its complement. Each pass writes every
//   register, then reads the registers back through both read ports at once. Read port 1
//   walks upward and read port 2 walks downward. The block reports pass/fail and
//   diagnostics for the first failure. The RF port outputs only matter while busy is
//   high, because an external mux hands the RF to this block only during a test.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   start                     begin a test (sampled only in IDLE or DONE)
//   read1Data, read2Data      RF combinational read data
//   err                       RF error flag, checked on every WRITE/READ edge
//   writeRegSel/Data/En       RF write port (select/data forced to 0 when not writing)
//   read1RegSel, read2RegSel  RF read selects (0 outside READ)
//   busy                      high in WRITE/READ
//   done                      level, high in DONE until next start or rst
//   pass                      1 when done and nothing went wrong
//   fail_err                  first failure came from err, not a data mismatch
//   fail_port                 0 = read port 1 mismatched, 1 = read port 2 mismatched
//   fail_reg, fail_data       register index and data actually read at first failure

module regfile_bist #(
    parameter int REGWIDTH = 16,
    parameter int NUMREGS  = 8,
    localparam int SELW    = $clog2(NUMREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [REGWIDTH-1:0] read1Data,
    input  logic [REGWIDTH-1:0] read2Data,
    input  logic                err,
    output logic [SELW-1:0]     writeRegSel,
    output logic [REGWIDTH-1:0] writeData,
    output logic                writeEn,
    output logic [SELW-1:0]     read1RegSel,
    output logic [SELW-1:0]     read2RegSel,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail_err,
    output logic                fail_port,
    output logic [SELW-1:0]     fail_reg,
    output logic [REGWIDTH-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} stateT;

    localparam logic [SELW-1:0]     LASTIDX = SELW'(NUMREGS - 1);
    localparam logic [REGWIDTH-1:0] BASEPAT = {(REGWIDTH/2){2'b10}};

    stateT               state, stateNext;
    logic [SELW-1:0]     idx, idxNext;
    logic                phase, phaseNext;
    logic                passNext, failErrNext, failPortNext;
    logic [SELW-1:0]     failRegNext;
    logic [REGWIDTH-1:0] failDataNext;
    logic [SELW-1:0]     mirrorIdx;
    logic [REGWIDTH-1:0] expect1, expect2;

    // Alternating 10 pattern with the register index folded into the low bits, so that
    // every register holds a distinct value. Phase 1 uses the complement of that value.
    function automatic logic [REGWIDTH-1:0] patternOf(input logic [SELW-1:0] i, input logic ph);
        logic [REGWIDTH-1:0] b;
        b = BASEPAT ^ {{(REGWIDTH-SELW){1'b0}}, i};
        return ph ? ~b : b;
    endfunction

    // Read port 2 walks the file from the top so that both ports cover every register.
    assign mirrorIdx = LASTIDX - idx;
    assign expect1   = patternOf(idx, phase);
    assign expect2   = patternOf(mirrorIdx, phase);

    // State, walk position and result registers. Reset clears everything, so the
    // result outputs read 0 without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            phase     <= 1'b0;
            pass      <= 1'b0;
            fail_err  <= 1'b0;
            fail_port <= 1'b0;
            fail_reg  <= '0;
            fail_data <= '0;
        end else begin
            state     <= stateNext;
            idx       <= idxNext;
            phase     <= phaseNext;
            pass      <= passNext;
            fail_err  <= failErrNext;
            fail_port <= failPortNext;
            fail_reg  <= failRegNext;
            fail_data <= failDataNext;
        end
    end

    // Next-state logic and RF port decode. The RF ports depend only on state, idx and
    // phase, so writeEn drops as soon as reset forces the state back to IDLE.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        phaseNext    = phase;
        passNext     = pass;
        failErrNext  = fail_err;
        failPortNext = fail_port;
        failRegNext  = fail_reg;
        failDataNext = fail_data;
        writeRegSel  = '0;
        writeData    = '0;
        writeEn      = 1'b0;
        read1RegSel  = '0;
        read2RegSel  = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    stateNext    = WRITE;
                    idxNext      = '0;
                    phaseNext    = 1'b0;
                    passNext     = 1'b0;
                    failErrNext  = 1'b0;
                    failPortNext = 1'b0;
                    failRegNext  = '0;
                    failDataNext = '0;
                end
            end

            WRITE: begin
                busy        = 1'b1;
                writeEn     = 1'b1;
                writeRegSel = idx;
                writeData   = expect1;
                if (err) begin
                    stateNext    = DONE;
                    passNext     = 1'b0;
                    failErrNext  = 1'b1;
                    failPortNext = 1'b0;
                    failRegNext  = idx;
                    failDataNext = read1Data;
                end else if (idx == LASTIDX) begin
                    idxNext   = '0;
                    stateNext = READ;
                end else begin
                    idxNext = idx + SELW'(1);
                end
            end

            READ: begin
                busy        = 1'b1;
                read1RegSel = idx;
                read2RegSel = mirrorIdx;
                // An RF error outranks a data mismatch. Read port 1 outranks read port 2.
                if (err) begin
                    stateNext    = DONE;
                    passNext     = 1'b0;
                    failErrNext  = 1'b1;
                    failPortNext = 1'b0;
                    failRegNext  = idx;
                    failDataNext = read1Data;
                end else if (read1Data != expect1) begin
                    stateNext    = DONE;
                    passNext     = 1'b0;
                    failPortNext = 1'b0;
                    failRegNext  = idx;
                    failDataNext = read1Data;
                end else if (read2Data != expect2) begin
                    stateNext    = DONE;
                    passNext     = 1'b0;
                    failPortNext = 1'b1;
                    failRegNext  = mirrorIdx;
                    failDataNext = read2Data;
                end else if (idx == LASTIDX) begin
                    idxNext = '0;
                    if (!phase) begin
                        stateNext = WRITE;
                        phaseNext = 1'b1;
                    end else begin
                        stateNext = DONE;
                        passNext  = 1'b1;
                    end
                end else begin
                    idxNext = idx + SELW'(1);
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist
//   Directed bench for regfile_bist. A small behavioural register file hangs off the
//   BIST ports. That RF can have bit 0 of register 5 stuck at 0, and the bench drives
//   err directly. Expected writes and expected end-of-run results go into scoreboard
//   queues when a run is launched. They are popped when the DUT writes and when it
//   reaches done.

module tb_regfile_bist;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } wrT;

    typedef struct {
        int          doneEdge;
        int          busyCycles;
        logic        pass;
        logic        failErr;
        logic        failPort;
        logic [2:0]  failReg;
        logic [15:0] failData;
    } resultT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        err = 1'b0;
    logic        stuckEn = 1'b0;
    logic [15:0] read1Data, read2Data;
    logic [2:0]  writeRegSel, read1RegSel, read2RegSel, fail_reg;
    logic [15:0] writeData, fail_data;
    logic        writeEn, busy, done, pass, fail_err, fail_port;

    logic [15:0] rfMem [8];

    wrT     wrQ[$];
    resultT resQ[$];
    int     checks = 0;
    int     errors = 0;
    int     doneEdge, busyCycles;

    regfile_bist dut (
        .clk(clk), .rst(rst), .start(start),
        .read1Data(read1Data), .read2Data(read2Data), .err(err),
        .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .busy(busy), .done(done), .pass(pass),
        .fail_err(fail_err), .fail_port(fail_port),
        .fail_reg(fail_reg), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    // Behavioural RF: writes commit at the clock edge and reads are combinational with
    // no bypass. The optional fault keeps bit 0 of register 5 at 0.
    always_ff @(posedge clk) begin
        if (writeEn)
            rfMem[writeRegSel] <= (stuckEn && writeRegSel == 3'd5) ? (writeData & 16'hFFFE) : writeData;
    end
    assign read1Data = rfMem[read1RegSel];
    assign read2Data = rfMem[read2RegSel];

    function automatic logic [15:0] expPattern(input int i, input logic ph);
        logic [15:0] b;
        b = 16'hAAAA ^ 16'(i);
        return ph ? ~b : b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushWrites(input logic ph);
        for (int i = 0; i < 8; i++) begin
            wrT w;
            w.sel  = 3'(i);
            w.data = expPattern(i, ph);
            wrQ.push_back(w);
        end
    endtask

    task automatic pushResult(input int dEdge, input logic p, input logic fe, input logic fp,
                              input logic [2:0] fr, input logic [15:0] fd);
        resultT r;
        r.doneEdge   = dEdge;
        r.busyCycles = dEdge;
        r.pass       = p;
        r.failErr    = fe;
        r.failPort   = fp;
        r.failReg    = fr;
        r.failData   = fd;
        resQ.push_back(r);
    endtask

    // Pulses start so that it is sampled by exactly one edge, or leaves it high.
    // Returns #1 after that start-sampling edge (edge 0).
    task automatic applyStimulus(input logic holdStart);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen. If errEdge is nonzero, err
    // is high only across that edge. Gives -1 if done never rises within maxEdges.
    task automatic waitDone(input int maxEdges, input int errEdge, output int dEdge, output int bCycles);
        dEdge   = -1;
        bCycles = 0;
        for (int e = 0; e <= maxEdges; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
                err = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                dEdge = e;
                break;
            end
            if (busy) bCycles++;
            if (e + 1 == errEdge) err = 1'b1;
        end
    endtask

    task automatic checkResult(input string tag, input int dEdge, input int bCycles);
        resultT r;
        checks++;
        assert (resQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s result queue: observed empty expected entry", tag);
        end
        if (resQ.size() != 0) begin
            r = resQ.pop_front();
            checkOutput({tag, " doneEdge"}, 64'(dEdge), 64'(r.doneEdge));
            checkOutput({tag, " busyCycles"}, 64'(bCycles), 64'(r.busyCycles));
            checkOutput({tag, " done"}, 64'(done), 64'(1));
            checkOutput({tag, " pass"}, 64'(pass), 64'(r.pass));
            checkOutput({tag, " fail_err"}, 64'(fail_err), 64'(r.failErr));
            checkOutput({tag, " fail_port"}, 64'(fail_port), 64'(r.failPort));
            checkOutput({tag, " fail_reg"}, 64'(fail_reg), 64'(r.failReg));
            checkOutput({tag, " fail_data"}, 64'(fail_data), 64'(r.failData));
        end
        checkOutput({tag, " writes left"}, 64'(wrQ.size()), 64'(0));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " write port"}, 64'({writeEn, writeRegSel, writeData}), 64'(0));
        checkOutput({tag, " read sels"}, 64'({read1RegSel, read2RegSel}), 64'(0));
        checkOutput({tag, " status"}, 64'({busy, done, pass, fail_err, fail_port}), 64'(0));
        checkOutput({tag, " fail diag"}, 64'({fail_reg, fail_data}), 64'(0));
    endtask

    // Write-port monitor: each BIST write must match the next expected one. While
    // writeEn is low, the write select and write data must be 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (writeEn) begin
                checks++;
                assert (wrQ.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected write: observed sel %0d data %h expected none", writeRegSel, writeData);
                end
                if (wrQ.size() != 0) begin
                    wrT w;
                    w = wrQ.pop_front();
                    checkOutput("write sel", 64'(writeRegSel), 64'(w.sel));
                    checkOutput("write data", 64'(writeData), 64'(w.data));
                end
            end else begin
                checkOutput("idle write port", 64'({writeRegSel, writeData}), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset, then idle with start low.
        #12;
        checkIdle("por");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("post-reset idle");

        // Reset in the middle of a cycle while writing.
        $display("[TB] mid-cycle reset during WRITE");
        pushWrites(1'b0);
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("writeEn before rst", 64'(writeEn), 64'(1));
        rst = 1'b1;
        #1;
        checkIdle("async rst");
        wrQ.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("after rst release");

        // Good RF: full two-pass run.
        $display("[TB] good RF full run");
        pushWrites(1'b0);
        pushWrites(1'b1);
        pushResult(32, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1'b0);
        waitDone(40, 0, doneEdge, busyCycles);
        checkResult("good run", doneEdge, busyCycles);

        // Register 5 bit 0 stuck at 0. Read port 2 sees it at phase 0, idx 2.
        $display("[TB] stuck-at fault on reg5");
        stuckEn = 1'b1;
        pushWrites(1'b0);
        pushResult(11, 1'b0, 1'b0, 1'b1, 3'd5, expPattern(5, 1'b0) & 16'hFFFE);
        applyStimulus(1'b0);
        waitDone(40, 0, doneEdge, busyCycles);
        checkResult("stuck reg5", doneEdge, busyCycles);
        stuckEn = 1'b0;

        // err on the third READ cycle of phase 1.
        $display("[TB] err during phase1 read");
        pushWrites(1'b0);
        pushWrites(1'b1);
        pushResult(27, 1'b0, 1'b1, 1'b0, 3'd2, expPattern(2, 1'b1));
        applyStimulus(1'b0);
        waitDone(40, 27, doneEdge, busyCycles);
        checkResult("err read", doneEdge, busyCycles);

        // Reset pulse at edge 10 of a run, then a clean run.
        $display("[TB] reset mid-run then rerun");
        pushWrites(1'b0);
        applyStimulus(1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("rst mid-run");
        checkOutput("rst mid-run writes left", 64'(wrQ.size()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        pushWrites(1'b0);
        pushWrites(1'b1);
        pushResult(32, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1'b0);
        waitDone(40, 0, doneEdge, busyCycles);
        checkResult("rerun after rst", doneEdge, busyCycles);

        // start held high: no restart while busy, then an immediate restart from DONE.
        $display("[TB] start held high");
        pushWrites(1'b0);
        pushWrites(1'b1);
        pushResult(32, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1'b1);
        waitDone(40, 0, doneEdge, busyCycles);
        checkResult("held start", doneEdge, busyCycles);
        pushWrites(1'b0);
        pushWrites(1'b1);
        pushResult(32, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("restart clears done", 64'({done, pass}), 64'(0));
        checkOutput("restart busy", 64'(busy), 64'(1));
        waitDone(40, 0, doneEdge, busyCycles);
        checkResult("restart from DONE", doneEdge, busyCycles);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
